// File: rtl/lcd_spi_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module  : lcd_spi_ctrl_if
// Desc    : Host command, image FIFO and LCD pin bundle
// Revision: 1.0
// ============================================================
interface lcd_spi_ctrl_if;
  logic [2:0] command;
  logic       valid_in;
  logic       busy;
  logic       error;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;
  logic       rst_lcd;
  logic       scl_lcd;
  logic       sda_lcd;
  logic       cs_lcd;
  logic       rs_lcd;
  logic       led_lcd;

  modport slave (
    input  command, valid_in, fifo_rd_data, fifo_empty,
    output busy, error, fifo_rd_en, rst_lcd, scl_lcd, sda_lcd, cs_lcd, rs_lcd, led_lcd
  );

  modport master (
    output command, valid_in, fifo_rd_data, fifo_empty,
    input  busy, error, fifo_rd_en, rst_lcd, scl_lcd, sda_lcd, cs_lcd, rs_lcd, led_lcd
  );
endinterface
`default_nettype wire

// File: rtl/lcd_spi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module  : lcd_spi_ctrl
// Desc    : Command-driven ST7735-class TFT controller, write-only SPI
// Revision: 1.0
// ============================================================
module lcd_spi_ctrl #(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 100,
  parameter int H_PIX      = 128,
  parameter int V_PIX      = 160
) (
  input  logic          clk,
  input  logic          rstn,
  lcd_spi_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(RST_CYCLES + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [3:0]  INIT_LEN  = 4'd6;
  localparam logic [3:0]  PRE_LEN   = 4'd11;
  localparam logic [14:0] PIX_TOTAL = 15'(H_PIX * V_PIX);
  localparam logic [7:0]  H_LAST    = 8'(H_PIX - 1);
  localparam logic [7:0]  V_LAST    = 8'(V_PIX - 1);

  localparam logic [2:0] CMD_INIT  = 3'd1;
  localparam logic [2:0] CMD_RED   = 3'd2;
  localparam logic [2:0] CMD_GREEN = 3'd3;
  localparam logic [2:0] CMD_BLUE  = 3'd4;
  localparam logic [2:0] CMD_IMAGE = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HW_RST   = 3'd1,
    RST_WAIT = 3'd2,
    LOAD     = 3'd3,
    FETCH    = 3'd4,
    SHIFT    = 3'd5,
    GAP      = 3'd6,
    DONE     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    M_INIT  = 2'd0,
    M_CLEAR = 2'd1,
    M_IMAGE = 2'd2
  } mode_t;

  state_t           r_state;
  state_t           w_next;
  mode_t            r_mode;
  logic [15:0]      r_color;
  logic [3:0]       r_idx;
  logic [14:0]      r_pix_cnt;
  logic             r_pix_lo;
  logic [TMR_W-1:0] r_tmr;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [6:0]       r_shift;
  logic             r_fetch_ph;
  logic             r_error;
  logic             r_rst_lcd;
  logic             r_scl;
  logic             r_sda;
  logic             r_cs;
  logic             r_rs;
  logic             r_led;

  logic       w_accept;
  logic       w_cmd_ok;
  logic       w_tmr_hit;
  logic       w_div_hit;
  logic       w_bit_end;
  logic       w_pix_phase;
  logic       w_img_byte;
  logic       w_end;
  logic [8:0] w_seq_byte;
  logic [8:0] w_load_byte;

  assign w_accept    = (r_state == IDLE) && bus.valid_in;
  assign w_cmd_ok    = (bus.command >= CMD_INIT) && (bus.command <= CMD_IMAGE);
  assign w_tmr_hit   = (r_tmr == TMR_W'(RST_CYCLES - 1));
  assign w_div_hit   = (r_div >= DIV_W'(CLK_DIV - 1));
  assign w_bit_end   = (r_state == SHIFT) && r_scl && w_div_hit;
  assign w_pix_phase = (r_mode != M_INIT) && (r_idx == PRE_LEN);
  assign w_img_byte  = w_pix_phase && (r_mode == M_IMAGE);
  assign w_end       = ((r_mode == M_INIT) && (r_idx == INIT_LEN)) ||
                       (w_pix_phase && (r_pix_cnt == PIX_TOTAL));

  // {rs, byte} for the init script or the window/write prefix
  always_comb begin
    w_seq_byte = 9'h000;
    if (r_mode == M_INIT) begin
      case (r_idx)
        4'd0:    w_seq_byte = 9'h011;
        4'd1:    w_seq_byte = 9'h03A;
        4'd2:    w_seq_byte = 9'h105;
        4'd3:    w_seq_byte = 9'h036;
        4'd4:    w_seq_byte = 9'h100;
        4'd5:    w_seq_byte = 9'h029;
        default: w_seq_byte = 9'h000;
      endcase
    end else begin
      case (r_idx)
        4'd0:             w_seq_byte = 9'h02A;
        4'd1, 4'd2, 4'd3: w_seq_byte = 9'h100;
        4'd4:             w_seq_byte = {1'b1, H_LAST};
        4'd5:             w_seq_byte = 9'h02B;
        4'd6, 4'd7, 4'd8: w_seq_byte = 9'h100;
        4'd9:             w_seq_byte = {1'b1, V_LAST};
        4'd10:            w_seq_byte = 9'h02C;
        default:          w_seq_byte = 9'h000;
      endcase
    end
  end

  assign w_load_byte = w_pix_phase ? {1'b1, (r_pix_lo ? r_color[7:0] : r_color[15:8])}
                                   : w_seq_byte;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_cmd_ok) begin
          if (bus.command == CMD_INIT)       w_next = HW_RST;
          else if (bus.command == CMD_IMAGE) w_next = bus.fifo_empty ? DONE : LOAD;
          else                               w_next = LOAD;
        end
      end
      HW_RST:   if (w_tmr_hit) w_next = RST_WAIT;
      RST_WAIT: if (w_tmr_hit) w_next = LOAD;
      LOAD: begin
        if (w_end)           w_next = DONE;
        else if (w_img_byte) w_next = bus.fifo_empty ? DONE : FETCH;
        else                 w_next = SHIFT;
      end
      FETCH:    if (r_fetch_ph) w_next = SHIFT;
      SHIFT:    if (w_bit_end && (r_bit == 3'd7)) w_next = GAP;
      GAP:      w_next = LOAD;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_mode     <= M_INIT;
      r_color    <= 16'h0000;
      r_idx      <= 4'd0;
      r_pix_cnt  <= 15'd0;
      r_pix_lo   <= 1'b0;
      r_tmr      <= '0;
      r_div      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 7'd0;
      r_fetch_ph <= 1'b0;
      r_error    <= 1'b0;
      r_rst_lcd  <= 1'b1;
      r_scl      <= 1'b0;
      r_sda      <= 1'b0;
      r_cs       <= 1'b1;
      r_rs       <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx     <= 4'd0;
            r_pix_cnt <= 15'd0;
            r_pix_lo  <= 1'b0;
            r_tmr     <= '0;
            r_error   <= !w_cmd_ok || ((bus.command == CMD_IMAGE) && bus.fifo_empty);
            case (bus.command)
              CMD_INIT: begin
                r_mode    <= M_INIT;
                r_rst_lcd <= 1'b0;
              end
              CMD_RED: begin
                r_mode  <= M_CLEAR;
                r_color <= 16'hF800;
              end
              CMD_GREEN: begin
                r_mode  <= M_CLEAR;
                r_color <= 16'h07E0;
              end
              CMD_BLUE: begin
                r_mode  <= M_CLEAR;
                r_color <= 16'h001F;
              end
              CMD_IMAGE: r_mode <= M_IMAGE;
              default: ;
            endcase
          end
        end
        HW_RST: begin
          if (w_tmr_hit) begin
            r_tmr     <= '0;
            r_rst_lcd <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        RST_WAIT: if (!w_tmr_hit) r_tmr <= r_tmr + 1'b1;
        LOAD: begin
          if (w_end || (w_img_byte && bus.fifo_empty)) begin
            r_cs  <= 1'b1;
            r_scl <= 1'b0;
            r_sda <= 1'b0;
            r_rs  <= 1'b0;
            if (!w_end)            r_error <= 1'b1;
            if (r_mode == M_INIT)  r_led   <= 1'b1;
          end else begin
            r_cs <= 1'b0;
            if (w_pix_phase) begin
              r_pix_lo <= !r_pix_lo;
              if (r_pix_lo) r_pix_cnt <= r_pix_cnt + 15'd1;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
            if (w_img_byte) begin
              r_fetch_ph <= 1'b0;
            end else begin
              // LOAD counts as the first low clock of the MSB
              r_shift <= w_load_byte[6:0];
              r_sda   <= w_load_byte[7];
              r_rs    <= w_load_byte[8];
              r_bit   <= 3'd0;
              r_div   <= DIV_W'(1);
            end
          end
        end
        FETCH: begin
          if (!r_fetch_ph) begin
            r_fetch_ph <= 1'b1;
          end else begin
            r_shift <= bus.fifo_rd_data[6:0];
            r_sda   <= bus.fifo_rd_data[7];
            r_rs    <= 1'b1;
            r_bit   <= 3'd0;
            r_div   <= '0;
          end
        end
        SHIFT: begin
          if (!w_div_hit) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            r_scl <= !r_scl;
            if (r_scl && (r_bit != 3'd7)) begin
              r_bit   <= r_bit + 3'd1;
              r_sda   <= r_shift[6];
              r_shift <= {r_shift[5:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state != IDLE) && (r_state != DONE);
  assign bus.error      = r_error;
  assign bus.fifo_rd_en = (r_state == FETCH) && !r_fetch_ph;
  assign bus.rst_lcd    = r_rst_lcd;
  assign bus.scl_lcd    = r_scl;
  assign bus.sda_lcd    = r_sda;
  assign bus.cs_lcd     = r_cs;
  assign bus.rs_lcd     = r_rs;
  assign bus.led_lcd    = r_led;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module  : tb_lcd_spi_ctrl
// Desc    : Scoreboard bench for lcd_spi_ctrl on a small panel geometry
// Revision: 1.0
// ============================================================
module tb_lcd_spi_ctrl;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 100;
  localparam int H_PIX      = 4;
  localparam int V_PIX      = 3;
  localparam int PIX_BYTES  = H_PIX * V_PIX * 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_spi_ctrl_if bus();

  lcd_spi_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES),
    .H_PIX      (H_PIX),
    .V_PIX      (V_PIX)
  ) dut (
    .clk  (clk),
    .rstn (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [8:0] out_vec();
    return {bus.busy, bus.error, bus.fifo_rd_en, bus.rst_lcd, bus.scl_lcd,
            bus.sda_lcd, bus.cs_lcd, bus.rs_lcd, bus.led_lcd};
  endfunction

  // Reference byte streams, {rs, byte}
  function automatic void push_init();
    exp_q.push_back(9'h011); exp_q.push_back(9'h03A); exp_q.push_back(9'h105);
    exp_q.push_back(9'h036); exp_q.push_back(9'h100); exp_q.push_back(9'h029);
  endfunction

  function automatic void push_prefix();
    exp_q.push_back(9'h02A);
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, 8'(H_PIX - 1)});
    exp_q.push_back(9'h02B);
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, 8'(V_PIX - 1)});
    exp_q.push_back(9'h02C);
  endfunction

  function automatic void push_clear(input logic [15:0] color);
    for (int p = 0; p < H_PIX * V_PIX; p++) begin
      exp_q.push_back({1'b1, color[15:8]});
      exp_q.push_back({1'b1, color[7:0]});
    end
  endfunction

  // Decodes mode-0 SPI bytes and scores them against the queue
  task automatic monitor_loop();
    logic [7:0] sh = 8'd0;
    logic       rs0 = 1'b0;
    logic       bad = 1'b0;
    logic       prev = 1'b0;
    int         nb = 0;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb   = 0;
        prev = 1'b0;
      end else begin
        if (bus.scl_lcd && !prev) begin
          if (nb == 0) begin
            rs0 = bus.rs_lcd;
            bad = 1'b0;
          end
          if (bus.cs_lcd || (bus.rs_lcd !== rs0)) bad = 1'b1;
          sh = {sh[6:0], bus.sda_lcd};
          nb++;
          if (nb == 8) begin
            nb = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL spi_byte: got rs=%0d data=%02h, required no byte", rs0, sh);
            end else begin
              exp = exp_q.pop_front();
              if (({rs0, sh} !== exp) || bad) begin
                errors++;
                $display("FAIL spi_byte: got rs=%0d data=%02h framing_err=%0d, required rs=%0d data=%02h",
                         rs0, sh, bad, exp[8], exp[7:0]);
              end
            end
          end
        end else if (bus.cs_lcd) begin
          nb = 0;
        end
        prev = bus.scl_lcd;
      end
    end
  endtask

  // FIFO model: fresh random byte per read, noise otherwise
  task automatic fifo_loop();
    logic pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
        bus.fifo_rd_data = 8'h00;
      end else if (pending) begin
        pending = 1'b0;
      end else if (bus.fifo_rd_en) begin
        bus.fifo_rd_data = 8'($urandom);
        exp_q.push_back({1'b1, bus.fifo_rd_data});
        rd_cnt++;
        pending = 1'b1;
      end else begin
        bus.fifo_rd_data = 8'($urandom);
      end
    end
  endtask

  task automatic issue(input logic [2:0] cmd);
    @(negedge clk);
    bus.command  = cmd;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int   n;
    int   r0;
    int   k;
    logic cs_low;

    bus.command    = 3'd0;
    bus.valid_in   = 1'b0;
    bus.fifo_empty = 1'b1;
    fork
      monitor_loop();
      fifo_loop();
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, out_vec()}, 32'b000100100);
    rst = 1'b0;

    // Init, with a stray valid_in during the reset pulse
    push_init();
    issue(3'd1);
    check("init_busy", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (!bus.rst_lcd && (n < 1000)) begin
      if (n == 10) begin
        bus.command  = 3'd2;
        bus.valid_in = 1'b1;
      end
      if (n == 11) bus.valid_in = 1'b0;
      n++;
      @(negedge clk);
    end
    check("rst_lcd_low_clocks", n, RST_CYCLES);
    wait_idle(1800, "init_done");
    check("init_led", {31'd0, bus.led_lcd}, 32'd1);
    check("init_error", {31'd0, bus.error}, 32'd0);
    check("init_bytes_left", exp_q.size(), 0);

    // Image with empty FIFO
    bus.fifo_empty = 1'b1;
    r0 = rd_cnt;
    issue(3'd5);
    cs_low = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.cs_lcd) cs_low = 1'b1;
    end
    check("empty_img_error", {31'd0, bus.error}, 32'd1);
    check("empty_img_busy", {31'd0, bus.busy}, 32'd0);
    check("empty_img_reads", rd_cnt - r0, 0);
    check("empty_img_cs_low", {31'd0, cs_low}, 32'd0);

    // Clear red
    push_prefix();
    push_clear(16'hF800);
    issue(3'd2);
    check("red_error_cleared", {31'd0, bus.error}, 32'd0);
    wait_idle(5000, "red_done");
    check("red_bytes_left", exp_q.size(), 0);

    // Full image from FIFO
    bus.fifo_empty = 1'b0;
    r0 = rd_cnt;
    push_prefix();
    issue(3'd5);
    wait_idle(20000, "img_done");
    check("img_reads", rd_cnt - r0, PIX_BYTES);
    check("img_bytes_left", exp_q.size(), 0);
    check("img_error", {31'd0, bus.error}, 32'd0);

    // Image aborted by FIFO running dry
    k  = $urandom_range(PIX_BYTES - 1, 1);
    r0 = rd_cnt;
    push_prefix();
    issue(3'd5);
    n = 0;
    while (((rd_cnt - r0) < k) && (n < 20000)) begin
      @(negedge clk);
      n++;
    end
    bus.fifo_empty = 1'b1;
    wait_idle(5000, "abort_done");
    check("abort_error", {31'd0, bus.error}, 32'd1);
    check("abort_cs", {31'd0, bus.cs_lcd}, 32'd1);
    check("abort_reads", rd_cnt - r0, k);
    check("abort_bytes_left", exp_q.size(), 0);

    // Clear green clears the error
    push_prefix();
    push_clear(16'h07E0);
    issue(3'd3);
    check("green_error_cleared", {31'd0, bus.error}, 32'd0);
    wait_idle(5000, "green_done");
    check("green_bytes_left", exp_q.size(), 0);

    // Asynchronous reset in the middle of a blue clear
    push_prefix();
    push_clear(16'h001F);
    issue(3'd4);
    repeat (150 + $urandom_range(40, 0)) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {23'd0, out_vec()}, 32'b000100100);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Invalid command
    issue(3'd6);
    check("invalid_error", {31'd0, bus.error}, 32'd1);
    repeat (3) @(negedge clk);
    check("invalid_busy", {31'd0, bus.busy}, 32'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_spi_ctrl.md
Name: lcd_spi_ctrl

Overview:
- Command-driven controller for a 128x160 RGB565 TFT LCD (ST7735-class) with a 4-wire write-only SPI interface.
- Accepts one 3-bit command from the host: init, clear to solid red/green/blue, or stream an image from an upstream byte FIFO.
- Handles the LCD hardware reset, SPI byte serialisation, D/C select and backlight enable.

Parameters:
- CLK_DIV, 2, system clocks per SCL half-period (SCL = clk/(2*CLK_DIV)).
- RST_CYCLES, 100, clocks rst_lcd is held low, and again the post-reset wait.
- H_PIX, 128, display width in pixels (column window 0..H_PIX-1).
- V_PIX, 160, display height in pixels (row window 0..V_PIX-1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous, active-high reset (port name kept per codebase); clears all state.
- command  in  3  1=init, 2=clear_red, 3=clear_green, 4=clear_blue, 5=show_image; 0,6,7 invalid.
- valid_in  in  1  one-cycle strobe qualifying command.
- busy  out  1  high while a command executes.
- error  out  1  sticky error flag.
- fifo_rd_en  out  1  one-cycle read request to the image FIFO.
- fifo_rd_data  in  8  FIFO byte, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- rst_lcd  out  1  LCD reset, active low.
- scl_lcd  out  1  SPI clock, idle low.
- sda_lcd  out  1  SPI data, MSB first.
- cs_lcd  out  1  SPI chip select, active low.
- rs_lcd  out  1  0=command byte, 1=data byte.
- led_lcd  out  1  backlight enable.

Behaviour:
- Reset values: busy=0, error=0, fifo_rd_en=0, rst_lcd=1, scl_lcd=0, sda_lcd=0, cs_lcd=1, rs_lcd=0, led_lcd=0; FSM in IDLE.
- Command acceptance:
  - Commands are sampled only in IDLE when valid_in=1.
  - busy rises on the next clock edge.
  - valid_in while busy is ignored and does not set error.
  - Accepting an invalid code (0,6,7) sets error, stays in IDLE, and leaves busy at 0.
  - Any accepted valid command clears error.
- SPI byte engine (mode 0):
  - cs_lcd is low from the first byte to the end of the command.
  - rs_lcd and sda_lcd are set while scl_lcd is low; the LCD samples on the scl rising edge.
  - Each bit occupies 2*CLK_DIV clocks; one idle clock separates bytes.
  - After the last byte: cs_lcd=1, scl_lcd=0.
- Init (1), in order:
  - rst_lcd=0 for RST_CYCLES, then rst_lcd=1 and wait RST_CYCLES.
  - Send: cmd 0x11; cmd 0x3A, data 0x05; cmd 0x36, data 0x00; cmd 0x29.
  - Then led_lcd=1 (held until reset) and return to IDLE.
  - Total duration is under 1000 clocks with the default parameters.
- Window/write prefix, used by commands 2-5: cmd 0x2A, data 00,00,00,H_PIX-1; cmd 0x2B, data 00,00,00,V_PIX-1; cmd 0x2C.
- Clear (2/3/4):
  - After the prefix, send H_PIX*V_PIX pixels, each as 2 data bytes, high byte first.
  - Colours: red=0xF800, green=0x07E0, blue=0x001F.
  - A 15-bit pixel counter terminates the stream at 20480 pixels.
- Show image (5):
  - If fifo_empty=1 at acceptance: set error, busy returns to 0 next cycle, no SPI activity, cs_lcd stays 1.
  - Otherwise send the prefix, then H_PIX*V_PIX*2 data bytes.
  - Per byte: if fifo_empty=0, pulse fifo_rd_en for one clock, latch fifo_rd_data the next clock, then shift it out.
  - If fifo_empty=1 when a byte is needed: abort, set error, cs_lcd=1, return to IDLE.
- Commands 2-5 do not require a prior init.
- FSM states: IDLE, HW_RST, RST_WAIT, LOAD (selects next byte from the init/prefix/pixel source), FETCH (FIFO read), SHIFT, GAP, DONE. DONE drops busy and returns to IDLE.
- An asynchronous reset mid-operation returns all outputs to their reset values immediately, including led_lcd=0.

Test Plan:
- Reset, then command=1 with a 1-cycle valid_in:
  - busy=1 next cycle.
  - rst_lcd low for exactly 100 clocks.
  - Decoded SPI bytes are 0x11(rs0), 0x3A(rs0), 0x05(rs1), 0x36(rs0), 0x00(rs1), 0x29(rs0).
  - led_lcd=1 and busy=0 within 1800 clocks; error=0.
- command=5 with fifo_empty=1:
  - error=1, busy returns to 0, no fifo_rd_en, cs_lcd stays 1.
- command=2 after init:
  - The 11-byte window prefix is correct.
  - Followed by exactly 40960 data bytes alternating 0xF8, 0x00; busy drops within 3,000,000 clocks.
- command=5, fifo_empty=0, fifo_rd_data changed 0xAA, then 0x94, then 0xB3, then 0x26 over time:
  - Each pixel byte on sda equals the value present the cycle after its fifo_rd_en pulse.
  - 40960 fifo_rd_en pulses in total.
- command=5, then fifo_empty raised mid-stream:
  - Abort, error=1, cs_lcd=1, busy=0.
  - A subsequent command=3 clears error and streams 0x07, 0xE0.
- command=6 with valid_in=1:
  - error=1, busy stays 0.
- Second valid_in during init:
  - Ignored; the init byte sequence is unchanged.
